// File: rtl/syst_pkg.sv
// Shared types for the systolic array input stage.
package syst_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StDrain  = 2'd2
  } feeder_state_t;

  // Drain counter must be able to hold n_rows - 1 and count down to 1.
  function automatic int unsigned drain_cnt_w(input int unsigned n_rows);
    return (n_rows + 1 > 2) ? $clog2(n_rows + 1) : 1;
  endfunction

endpackage

// File: rtl/syst_delay_line.sv
// Enable-gated shift register carrying {last, valid, data}; DEPTH registered stages.
module syst_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic             last_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic             last_o,
  output logic [WIDTH-1:0] data_o,
  output logic             any_valid_o
);

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0]            last_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;

  // Control bits: async-reset so a reset discards every in-flight beat.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      valid_q <= '0;
      last_q  <= '0;
    end else if (en_i) begin
      valid_q[0] <= valid_i;
      last_q[0]  <= last_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  // Data payload: no reset, only meaningful alongside its valid bit.
  always_ff @(posedge clk) begin
    if (en_i) begin
      data_q[0] <= data_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign valid_o     = valid_q[DEPTH-1];
  assign last_o      = last_q[DEPTH-1];
  assign data_o      = data_q[DEPTH-1];
  assign any_valid_o = |valid_q;

endmodule

// File: rtl/syst_skew_feeder.sv
// Systolic array input stage: triangular row skew plus frame drain control.
module syst_skew_feeder
  import syst_pkg::*;
#(
  parameter int unsigned N_ROWS  = 4,
  parameter int unsigned X_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      arstn,
  input  logic                      enable,
  input  logic [N_ROWS*X_WIDTH-1:0] s_data_i,
  input  logic                      s_valid_i,
  input  logic                      s_last_i,
  output logic                      s_ready_o,
  output logic [N_ROWS*X_WIDTH-1:0] x_o,
  output logic [N_ROWS-1:0]         valid_x_o,
  output logic                      last_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned CntW = drain_cnt_w(N_ROWS);

  feeder_state_t   state_q;
  logic [CntW-1:0] cnt_q;
  logic            done_q;
  logic            accept;

  logic [N_ROWS-1:0] row_valid;
  logic [N_ROWS-1:0] row_last;
  logic [N_ROWS-1:0] row_any;

  assign s_ready_o = enable & (state_q != StDrain);
  assign accept    = s_valid_i & s_ready_o;

  // One delay line per row; row r gets r+1 stages, last rides only on the final row.
  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    localparam bit IsLast = (r == int'(N_ROWS) - 1);

    syst_delay_line #(
      .DEPTH(r + 1),
      .WIDTH(X_WIDTH)
    ) u_delay_line (
      .clk        (clk),
      .arstn      (arstn),
      .en_i       (enable),
      .valid_i    (accept),
      .last_i     (IsLast ? (s_last_i & accept) : 1'b0),
      .data_i     (s_data_i[r*X_WIDTH +: X_WIDTH]),
      .valid_o    (row_valid[r]),
      .last_o     (row_last[r]),
      .data_o     (x_o[r*X_WIDTH +: X_WIDTH]),
      .any_valid_o(row_any[r])
    );
  end

  // Frame FSM with drain counter; done is a registered one-edge pulse.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (enable) begin
        unique case (state_q)
          StIdle, StStream: begin
            if (accept) begin
              if (!s_last_i) begin
                state_q <= StStream;
              end else if (N_ROWS == 1) begin
                done_q  <= 1'b1;
                state_q <= StIdle;
              end else begin
                state_q <= StDrain;
                cnt_q   <= CntW'(N_ROWS - 1);
              end
            end
          end
          StDrain: begin
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign valid_x_o = row_valid;
  // Only the final row ever carries a set last bit.
  assign last_o    = |(row_last & row_valid);
  assign busy_o    = (state_q != StIdle) | (|row_any);
  assign done_o    = done_q;

endmodule
